msk_nlfsr_ks: RTL and testbench

- Second-generation two-share masked NLFSR keystream generator.
- Generalises the fixed 29/27-bit masked register pair: register lengths, linear tap masks and nonlinear tap positions are parameters.
- Adds a warm-up sequencer and a valid/ready keystream output, so downstream cipher logic consumes one masked keystream bit per handshake.
- Sits between the key/IV loader (parallel or serial) and the masked cipher datapath.

---
 rtl/msk_nlfsr_pkg.sv | 16 +
 rtl/msk_nlfsr_step.sv | 32 +++
 rtl/msk_nlfsr_ks.sv | 90 +++++++++
 tb/tb_msk_nlfsr_ks.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/msk_nlfsr_pkg.sv
// msk_nlfsr_pkg: shared types, default taps and masked feedback function for the masked NLFSR
package msk_nlfsr_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WARM = 2'd1, RUN = 2'd2} state_t;
  localparam logic [28:0] TAPS_A_DEF = 29'h08C9869;
  localparam logic [26:0] TAPS_B_DEF = 27'h02A4D17;
  localparam int NLA_HI_DEF = 28;
  localparam int NLA_LO_DEF = 20;
  localparam int NLB_HI_DEF = 10;
  localparam int NLB_LO_DEF = 6;
  // Shares XOR to hi&lo: share 1 keeps (h1&l1)^(h1|~l2), share 2 keeps (h2|~l2)^(h2&l1).
  function automatic logic mask_fb(input logic sel2, input logic h1, input logic l1,
                                   input logic h2, input logic l2, input logic lin,
                                   input logic x, input logic r);
    return (sel2 ? ((h2 | ~l2) ^ (h2 & l1)) : ((h1 & l1) ^ (h1 | ~l2))) ^ lin ^ x ^ r;
  endfunction
endpackage

// File: rtl/msk_nlfsr_step.sv
// msk_nlfsr_step: combinational one-step update of both masked shares
module msk_nlfsr_step
  import msk_nlfsr_pkg::*;
#(
  parameter int LA = 29,
  parameter int LB = 27,
  parameter logic [LA-1:0] TAPS_A = LA'(TAPS_A_DEF),
  parameter logic [LB-1:0] TAPS_B = LB'(TAPS_B_DEF),
  parameter int NLA_HI = NLA_HI_DEF,
  parameter int NLA_LO = NLA_LO_DEF,
  parameter int NLB_HI = NLB_HI_DEF,
  parameter int NLB_LO = NLB_LO_DEF
) (
  input  logic [LA-1:0] i_a1,
  input  logic [LA-1:0] i_a2,
  input  logic [LB-1:0] i_b1,
  input  logic [LB-1:0] i_b2,
  input  logic          i_r1,
  input  logic          i_r2,
  output logic [LA-1:0] o_a1,
  output logic [LA-1:0] o_a2,
  output logic [LB-1:0] o_b1,
  output logic [LB-1:0] o_b2
);
  // Shift right, masked feedback into the MSB of each register of each share
  always_comb begin
    o_a1 = {mask_fb(1'b0, i_a1[NLA_HI], i_a1[NLA_LO], i_a2[NLA_HI], i_a2[NLA_LO], ^(i_a1 & TAPS_A), i_b1[0], i_r1), i_a1[LA-1:1]};
    o_a2 = {mask_fb(1'b1, i_a1[NLA_HI], i_a1[NLA_LO], i_a2[NLA_HI], i_a2[NLA_LO], ^(i_a2 & TAPS_A), i_b2[0], i_r1), i_a2[LA-1:1]};
    o_b1 = {mask_fb(1'b0, i_b1[NLB_HI], i_b1[NLB_LO], i_b2[NLB_HI], i_b2[NLB_LO], ^(i_b1 & TAPS_B), i_a1[0], i_r2), i_b1[LB-1:1]};
    o_b2 = {mask_fb(1'b1, i_b1[NLB_HI], i_b1[NLB_LO], i_b2[NLB_HI], i_b2[NLB_LO], ^(i_b2 & TAPS_B), i_a2[0], i_r2), i_b2[LB-1:1]};
  end
endmodule

// File: rtl/msk_nlfsr_ks.sv
// msk_nlfsr_ks: two-share masked NLFSR keystream generator with warm-up and valid/ready output
module msk_nlfsr_ks
  import msk_nlfsr_pkg::*;
#(
  parameter int LA = 29,
  parameter int LB = 27,
  parameter logic [LA-1:0] TAPS_A = LA'(TAPS_A_DEF),
  parameter logic [LB-1:0] TAPS_B = LB'(TAPS_B_DEF),
  parameter int NLA_HI = NLA_HI_DEF,
  parameter int NLA_LO = NLA_LO_DEF,
  parameter int NLB_HI = NLB_HI_DEF,
  parameter int NLB_LO = NLB_LO_DEF,
  parameter int WARMUP = 112,
  localparam int W = LA + LB,
  localparam int CW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [W-1:0]  i_wdata1,
  input  logic [W-1:0]  i_wdata2,
  input  logic          i_ser_in_valid,
  input  logic          i_ser_in,
  input  logic          i_start,
  input  logic          i_halt,
  input  logic          i_r1,
  input  logic          i_r2,
  input  logic          i_ks_ready,
  output logic          o_ks_valid,
  output logic          o_ks1,
  output logic          o_ks2,
  output logic          o_busy,
  output logic [CW-1:0] o_warm_cnt,
  input  logic          i_rxor,
  output logic [W-1:0]  o_rdata1,
  output logic [W-1:0]  o_rdata2,
  output logic [W-1:0]  o_rdata_xor
);
  localparam logic [CW-1:0] WU = CW'(WARMUP);
  logic [LA-1:0] a1_q, a2_q, a1_d, a2_d, na1, na2;
  logic [LB-1:0] b1_q, b2_q, b1_d, b2_d, nb1, nb2;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  state_t state_q, state_d;
  logic act, step, shift, go;
  msk_nlfsr_step #(
    .LA(LA), .LB(LB), .TAPS_A(TAPS_A), .TAPS_B(TAPS_B),
    .NLA_HI(NLA_HI), .NLA_LO(NLA_LO), .NLB_HI(NLB_HI), .NLB_LO(NLB_LO)
  ) u_step (
    .i_a1(a1_q), .i_a2(a2_q), .i_b1(b1_q), .i_b2(b2_q), .i_r1(i_r1), .i_r2(i_r2),
    .o_a1(na1), .o_a2(na2), .o_b1(nb1), .o_b2(nb2)
  );
  // Load beats halt beats FSM; share registers, state and counter next values
  always_comb begin
    act = !i_load && !i_halt;
    step = act && (state_q == WARM || (state_q == RUN && i_ks_ready));
    shift = act && state_q == IDLE && i_ser_in_valid;
    go = act && state_q == IDLE && !i_ser_in_valid && i_start;
    cnt_inc = cnt_q + 1'b1;
    {a1_d, b1_d} = i_load ? i_wdata1 : shift ? {i_ser_in, a1_q, b1_q[LB-1:1]} : step ? {na1, nb1} : {a1_q, b1_q};
    {a2_d, b2_d} = i_load ? i_wdata2 : shift ? {i_ser_in, a2_q, b2_q[LB-1:1]} : step ? {na2, nb2} : {a2_q, b2_q};
    cnt_d = i_load ? '0 : (act && state_q == WARM) ? cnt_inc : cnt_q;
    state_d = i_load ? IDLE : go ? (WARMUP == 0 ? RUN : WARM) : (act && state_q == WARM && cnt_inc == WU) ? RUN : state_q;
  end
  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q <= '0;
      a2_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
      cnt_q <= '0;
      state_q <= IDLE;
    end else begin
      a1_q <= a1_d;
      a2_q <= a2_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  end
  assign o_ks_valid = state_q == RUN && !i_halt;
  assign o_ks1 = a1_q[0] ^ b1_q[0];
  assign o_ks2 = a2_q[0] ^ b2_q[0];
  assign o_busy = state_q != IDLE;
  assign o_warm_cnt = cnt_q;
  assign o_rdata1 = {a1_q, b1_q};
  assign o_rdata2 = {a2_q, b2_q};
  assign o_rdata_xor = o_rdata1 ^ (i_rxor ? o_rdata2 : '0);
endmodule

// File: tb/tb_msk_nlfsr_ks.sv
// tb_msk_nlfsr_ks: scoreboard bench for the masked NLFSR keystream generator
module tb_msk_nlfsr_ks;
  localparam int W = 56;
  localparam logic [28:0] TA = 29'h08C9869;
  localparam logic [26:0] TB = 27'h02A4D17;
  localparam logic [W-1:0] W1 = 56'hA5A5_5A5A_0F0F_33;
  localparam logic [W-1:0] W2 = 56'h3C3C_C3C3_F0F0_CC;
  logic clk = 0, rst = 1;
  logic i_load = 0, i_ser_in_valid = 0, i_ser_in = 0, i_start = 0, i_halt = 0;
  logic i_r1 = 0, i_r2 = 0, i_ks_ready = 0, i_rxor = 0;
  logic [W-1:0] i_wdata1 = '0, i_wdata2 = '0;
  logic o_ks_valid, o_ks1, o_ks2, o_busy;
  logic [6:0] o_warm_cnt;
  logic [W-1:0] o_rdata1, o_rdata2, o_rdata_xor;
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] model;
  logic [W-1:0] exp_st_q[$];
  logic exp_ks_q[$];

  msk_nlfsr_ks dut (
    .clk(clk), .rst(rst), .i_load(i_load), .i_wdata1(i_wdata1), .i_wdata2(i_wdata2),
    .i_ser_in_valid(i_ser_in_valid), .i_ser_in(i_ser_in), .i_start(i_start), .i_halt(i_halt),
    .i_r1(i_r1), .i_r2(i_r2), .i_ks_ready(i_ks_ready), .o_ks_valid(o_ks_valid), .o_ks1(o_ks1),
    .o_ks2(o_ks2), .o_busy(o_busy), .o_warm_cnt(o_warm_cnt), .i_rxor(i_rxor),
    .o_rdata1(o_rdata1), .o_rdata2(o_rdata2), .o_rdata_xor(o_rdata_xor)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mstep(input logic [W-1:0] s);
    logic [28:0] a;
    logic [26:0] b;
    logic fa, fb;
    a = s[55:27];
    b = s[26:0];
    fa = (a[28] & a[20]) ^ (^(a & TA)) ^ b[0];
    fb = (b[10] & b[6]) ^ (^(b & TB)) ^ a[0];
    return {fa, a[28:1], fb, b[26:1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd();
    i_r1 = 1'($urandom);
    i_r2 = 1'($urandom);
  endtask

  task automatic do_load(input logic [W-1:0] d1, input logic [W-1:0] d2);
    i_wdata1 = d1;
    i_wdata2 = d2;
    i_load = 1;
    tick();
    i_load = 0;
  endtask

  task automatic test_reset();
    tick();
    n_tests++;
    if ({o_ks_valid, o_busy, o_ks1, o_ks2, o_warm_cnt, o_rdata1, o_rdata2, o_rdata_xor} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b busy=%b cnt=%0d rdata1=%h rdata2=%h, required all 0", o_ks_valid, o_busy, o_warm_cnt, o_rdata1, o_rdata2);
    end
    rst = 0;
    do_load(W1, W2);
    i_start = 1;
    tick();
    i_start = 0;
    repeat (50) begin rnd(); tick(); end
    n_tests++;
    if (o_warm_cnt !== 7'd50) begin n_fail++; $display("FAIL warm_cnt_50: got %0d required 50", o_warm_cnt); end
    rst = 1;
    tick();
    n_tests++;
    if ({o_busy, o_warm_cnt, o_rdata1, o_rdata2, o_ks_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_warm: busy=%b cnt=%0d rdata1=%h rdata2=%h valid=%b, required all 0", o_busy, o_warm_cnt, o_rdata1, o_rdata2, o_ks_valid);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_load();
    i_rxor = 1;
    do_load(W1, W2);
    n_tests++;
    if (o_rdata_xor !== 56'h9999_9999_FFFF_FF) begin n_fail++; $display("FAIL load_xor: got %h required %h", o_rdata_xor, 56'h9999_9999_FFFF_FF); end
    n_tests++;
    if (o_rdata1 !== W1 || o_rdata2 !== W2) begin n_fail++; $display("FAIL load_shares: got %h/%h required %h/%h", o_rdata1, o_rdata2, W1, W2); end
    i_rxor = 0;
    #1;
    n_tests++;
    if (o_rdata_xor !== W1) begin n_fail++; $display("FAIL load_noxor: got %h required %h", o_rdata_xor, W1); end
    i_rxor = 1;
  endtask

  task automatic test_warmup();
    int lat;
    model = W1 ^ W2;
    i_start = 1;
    tick();
    i_start = 0;
    lat = 1;
    while (!o_ks_valid && lat < 300) begin rnd(); tick(); lat++; end
    repeat (112) model = mstep(model);
    n_tests++;
    if (lat !== 113) begin n_fail++; $display("FAIL warm_latency: got %0d cycles required 113", lat); end
    n_tests++;
    if (o_rdata_xor !== model) begin n_fail++; $display("FAIL warm_state: got %h required %h", o_rdata_xor, model); end
    n_tests++;
    if (o_warm_cnt !== 7'd112 || o_busy !== 1'b1) begin n_fail++; $display("FAIL warm_done: cnt=%0d busy=%b required 112/1", o_warm_cnt, o_busy); end
  endtask

  task automatic test_stall();
    logic [W-1:0] s1, s2;
    logic k1, k2, bad;
    s1 = o_rdata1;
    s2 = o_rdata2;
    k1 = o_ks1;
    k2 = o_ks2;
    bad = 0;
    i_ks_ready = 0;
    repeat (10) begin
      rnd();
      tick();
      if (o_rdata1 !== s1 || o_rdata2 !== s2 || o_ks1 !== k1 || o_ks2 !== k2 || o_ks_valid !== 1'b1) bad = 1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL stall_hold: got %h/%h ks=%b%b required %h/%h ks=%b%b", o_rdata1, o_rdata2, o_ks1, o_ks2, s1, s2, k1, k2); end
    i_halt = 1;
    #1;
    n_tests++;
    if (o_ks_valid !== 1'b0) begin n_fail++; $display("FAIL halt_run_valid: got %b required 0", o_ks_valid); end
    i_halt = 0;
  endtask

  task automatic test_back_to_back();
    logic e;
    for (int i = 0; i < 20; i++) begin
      rnd();
      i_ks_ready = 1;
      exp_ks_q.push_back(model[27] ^ model[0]);
      model = mstep(model);
      exp_st_q.push_back(model);
      #1;
      e = exp_ks_q.pop_front();
      n_tests++;
      if ((o_ks1 ^ o_ks2) !== e || o_ks_valid !== 1'b1) begin n_fail++; $display("FAIL ks_bit[%0d]: got %b valid=%b required %b", i, o_ks1 ^ o_ks2, o_ks_valid, e); end
      tick();
      i_ks_ready = 0;
      rnd();
      tick();
      n_tests++;
      if (o_rdata_xor !== exp_st_q[0]) begin n_fail++; $display("FAIL ks_state[%0d]: got %h required %h", i, o_rdata_xor, exp_st_q[0]); end
      void'(exp_st_q.pop_front());
    end
  endtask

  task automatic test_halt();
    int lat;
    logic bad;
    do_load(W2, W1);
    i_start = 1;
    tick();
    i_start = 0;
    lat = 1;
    repeat (30) begin rnd(); tick(); lat++; end
    n_tests++;
    if (o_warm_cnt !== 7'd30) begin n_fail++; $display("FAIL halt_cnt_pre: got %0d required 30", o_warm_cnt); end
    i_halt = 1;
    bad = 0;
    repeat (5) begin
      rnd();
      tick();
      lat++;
      if (o_warm_cnt !== 7'd30 || o_ks_valid !== 1'b0) bad = 1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL halt_hold: cnt=%0d valid=%b required 30/0", o_warm_cnt, o_ks_valid); end
    i_halt = 0;
    while (!o_ks_valid && lat < 400) begin rnd(); tick(); lat++; end
    n_tests++;
    if (lat !== 118) begin n_fail++; $display("FAIL halt_latency: got %0d cycles required 118", lat); end
    model = W1 ^ W2;
    repeat (112) model = mstep(model);
    n_tests++;
    if (o_rdata_xor !== model) begin n_fail++; $display("FAIL halt_state: got %h required %h", o_rdata_xor, model); end
  endtask

  task automatic test_load_in_run();
    logic [W-1:0] p, l1, l2;
    l1 = {$urandom, $urandom};
    l2 = {$urandom, $urandom};
    i_ks_ready = 1;
    rnd();
    do_load(l1, l2);
    i_ks_ready = 0;
    n_tests++;
    if (o_rdata1 !== l1 || o_rdata2 !== l2 || o_busy !== 1'b0 || o_ks_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_in_run: got %h/%h busy=%b valid=%b required %h/%h busy=0 valid=0", o_rdata1, o_rdata2, o_busy, o_ks_valid, l1, l2);
    end
    p = {$urandom, $urandom};
    i_ser_in_valid = 1;
    for (int k = 0; k < W; k++) begin
      i_ser_in = p[k];
      i_start = (k == W - 1);
      tick();
    end
    i_ser_in_valid = 0;
    i_start = 0;
    n_tests++;
    if (o_rdata1 !== p || o_rdata2 !== p) begin n_fail++; $display("FAIL serial_load: got %h/%h required %h", o_rdata1, o_rdata2, p); end
    n_tests++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL serial_start_ignored: busy=%b required 0", o_busy); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_warmup();
    test_stall();
    test_back_to_back();
    test_halt();
    test_load_in_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
